// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage RV32M multiply/divide unit:
// funct3 encodings, sequencer states and the iteration count.
package muldiv_pkg;

  localparam int ITERS = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Dual-lane conditional two's-complement negate; used both to take operand
// magnitudes and to restore the sign of the magnitude result.
module muldiv_sign_fix #(
  parameter int WA = 32,
  parameter int WB = 32
) (
  input  logic [WA-1:0] a,
  input  logic          neg_a,
  input  logic [WB-1:0] b,
  input  logic          neg_b,
  output logic [WA-1:0] fix_a,
  output logic [WB-1:0] fix_b
);

  assign fix_a = neg_a ? -a : a;
  assign fix_b = neg_b ? -b : b;

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide for the EX stage, fixed 34-cycle latency.
// Define RV32M_DIV_EN to build the divide/remainder datapath.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            Start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] OpA,
  input  logic [XLEN-1:0] OpB,
  input  logic            Flush,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result,
  output logic            Illegal
);

  state_t            state;
  state_t            state_next;
  logic [2:0]        op;
  logic              sign_a;
  logic              sign_b;
  logic [2*XLEN-1:0] opa_sh;
  logic [XLEN-1:0]   opb_r;
  logic [2*XLEN-1:0] acc;
  logic [5:0]        cnt;
  logic [XLEN-1:0]   result;

  logic              a_signed;
  logic              b_signed;
  logic              neg_a;
  logic              neg_b;
  logic [XLEN-1:0]   a_abs;
  logic [XLEN-1:0]   b_abs;
  logic              accept;

  logic [XLEN-1:0]   div_mag;
  logic              div_neg;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_fix;
  logic [XLEN-1:0]   res_word;

`ifdef RV32M_DIV_EN
  logic [XLEN:0]     prem;
  logic              div_zero;
  logic [XLEN:0]     shifted;
  logic [XLEN+1:0]   trial;
`else
  logic              illegal;
`endif

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (Funct3)
      F3_MULH, F3_DIV, F3_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      F3_MULHSU: a_signed = 1'b1;
      F3_MUL, F3_MULHU, F3_DIVU, F3_REMU: begin
        a_signed = 1'b0;
        b_signed = 1'b0;
      end
      default: begin
        a_signed = 1'b0;
        b_signed = 1'b0;
      end
    endcase
  end

  assign neg_a  = a_signed & OpA[XLEN-1];
  assign neg_b  = b_signed & OpB[XLEN-1];
  assign accept = (state == IDLE) && Start && !Flush;

  muldiv_sign_fix #(.WA(XLEN), .WB(XLEN)) u_capture (
    .a     (OpA),
    .neg_a (neg_a),
    .b     (OpB),
    .neg_b (neg_b),
    .fix_a (a_abs),
    .fix_b (b_abs)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef RV32M_DIV_EN
          state_next = CALC;
`else
          state_next = Funct3[2] ? DONE : CALC;
`endif
        end
      end
      CALC:    if (cnt == 6'(ITERS - 1)) state_next = SIGN;
      SIGN:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (Flush && (state != IDLE)) state_next = IDLE;
  end

`ifdef RV32M_DIV_EN
  // Restoring step: shift in the next dividend bit and try the subtraction.
  assign shifted = {prem[XLEN-1:0], opa_sh[XLEN-1]};
  assign trial   = {prem, opa_sh[XLEN-1]} - {2'b00, opb_r};
  assign div_mag = op[1] ? prem[XLEN-1:0] : opa_sh[XLEN-1:0];
  assign div_neg = op[1] ? sign_a : (sign_a ^ sign_b);
`else
  assign div_mag = '0;
  assign div_neg = 1'b0;
`endif

  muldiv_sign_fix #(.WA(2*XLEN), .WB(XLEN)) u_result (
    .a     (acc),
    .neg_a (sign_a ^ sign_b),
    .b     (div_mag),
    .neg_b (div_neg),
    .fix_a (prod_fix),
    .fix_b (div_fix)
  );

  always_comb begin
    res_word = prod_fix[XLEN-1:0];
    case (op)
      F3_MUL:                      res_word = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: res_word = prod_fix[2*XLEN-1:XLEN];
`ifdef RV32M_DIV_EN
      F3_DIV, F3_DIVU:             res_word = div_zero ? '1 : div_fix;
`else
      F3_DIV, F3_DIVU:             res_word = div_fix;
`endif
      default:                     res_word = div_fix;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      op     <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      opa_sh <= '0;
      opb_r  <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
`ifdef RV32M_DIV_EN
      prem     <= '0;
      div_zero <= 1'b0;
`else
      illegal  <= 1'b0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            op     <= Funct3;
            sign_a <= neg_a;
            sign_b <= neg_b;
            opa_sh <= {{XLEN{1'b0}}, a_abs};
            opb_r  <= b_abs;
            acc    <= '0;
            cnt    <= '0;
`ifdef RV32M_DIV_EN
            prem     <= '0;
            div_zero <= (OpB == '0);
`else
            if (Funct3[2]) begin
              result  <= '0;
              illegal <= 1'b1;
            end
`endif
          end
        end
        CALC: begin
          cnt <= cnt + 6'd1;
          if (!op[2]) begin
            if (opb_r[0]) acc <= acc + opa_sh;
            opa_sh <= opa_sh << 1;
            opb_r  <= opb_r >> 1;
          end
`ifdef RV32M_DIV_EN
          else begin
            prem   <= trial[XLEN+1] ? shifted : trial[XLEN:0];
            opa_sh <= {opa_sh[2*XLEN-2:0], ~trial[XLEN+1]};
          end
`endif
        end
        SIGN: begin
          if (!Flush) result <= res_word;
        end
        DONE: begin
`ifndef RV32M_DIV_EN
          illegal <= 1'b0;
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign Busy   = (state != IDLE);
  assign Done   = (state == DONE);
  assign Result = result;
`ifdef RV32M_DIV_EN
  assign Illegal = 1'b0;
`else
  assign Illegal = illegal;
`endif

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: latency, handshake, arithmetic results and
// control boundaries in both divide-enabled and divide-disabled builds.
module tb_ex_muldiv;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] OpA = '0;
  logic [31:0] OpB = '0;
  logic        Flush = 1'b0;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;
  logic        Illegal;

  int checks = 0;
  int failures = 0;
  int ndone;

  always #5 CLK = ~CLK;

  ex_muldiv #(.XLEN(32)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .Start   (Start),
    .Funct3  (Funct3),
    .OpA     (OpA),
    .OpB     (OpB),
    .Flush   (Flush),
    .Busy    (Busy),
    .Done    (Done),
    .Result  (Result),
    .Illegal (Illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one operation and watches 40 cycles; optionally pulses Start
  // (with other operands) in cycle pulse to prove it is ignored.
  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int lat,
                        input logic exp_ill, input int pulse);
    int          first_done = 0;
    int          cnt_done = 0;
    int          busy_bad = 0;
    logic [31:0] res_at_done = '0;
    logic        ill_at_done = 1'b0;
    logic        ill_after = 1'b1;
    @(negedge CLK);
    Start = 1'b1; Funct3 = f3; OpA = a; OpB = b;
    @(negedge CLK);
    Start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (Done) begin
        cnt_done++;
        if (first_done == 0) begin
          first_done  = cyc;
          res_at_done = Result;
          ill_at_done = Illegal;
        end
      end
      if (first_done != 0 && cyc == first_done + 1) ill_after = Illegal;
      if (Busy !== (cyc <= lat)) busy_bad++;
      if (cyc == pulse) begin
        Start = 1'b1; Funct3 = 3'b011; OpA = '1; OpB = '1;
      end else begin
        Start = 1'b0;
      end
      @(negedge CLK);
    end
    check({tag, ".done_cycle"}, 32'(first_done), 32'(lat));
    check({tag, ".done_count"}, 32'(cnt_done), 32'd1);
    check({tag, ".busy_bad_cycles"}, 32'(busy_bad), 32'd0);
    check({tag, ".result"}, res_at_done, exp_res);
    check({tag, ".illegal"}, {31'd0, ill_at_done}, {31'd0, exp_ill});
    check({tag, ".illegal_clear"}, {31'd0, ill_after}, 32'd0);
    check({tag, ".result_held"}, Result, exp_res);
  endtask

  initial begin
    #2;
    check("reset.busy", {31'd0, Busy}, 32'd0);
    check("reset.done", {31'd0, Done}, 32'd0);
    check("reset.result", Result, 32'd0);
    check("reset.illegal", {31'd0, Illegal}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    run_op("mul_neg",  3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b0, 0);
    run_op("mulh",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 1'b0, 0);
    run_op("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b0, 0);
    run_op("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1'b0, 0);

`ifdef RV32M_DIV_EN
    run_op("div_neg",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b0, 0);
    run_op("rem_neg",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b0, 0);
    run_op("divu",     3'b101, 32'd100, 32'd7, 32'd14, 34, 1'b0, 0);
    run_op("remu",     3'b111, 32'd100, 32'd7, 32'd2, 34, 1'b0, 0);
    run_op("divu_z",   3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 34, 1'b0, 0);
    run_op("rem_z",    3'b110, 32'd5, 32'd0, 32'd5, 34, 1'b0, 0);
    run_op("div_negz", 3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 34, 1'b0, 0);
    run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 1'b0, 0);
    run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, 1'b0, 0);
`else
    run_op("div_ill",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'd0, 1, 1'b1, 0);
    run_op("remu_ill", 3'b111, 32'd100, 32'd7, 32'd0, 1, 1'b1, 0);
`endif

    run_op("start_calc_ignored", 3'b000, 32'd3, 32'd4, 32'd12, 34, 1'b0, 20);
    run_op("start_done_ignored", 3'b000, 32'h0001_2345, 32'h10, 32'h0012_3450, 34, 1'b0, 34);

    // Flush at cycle 10: back to IDLE, no Done, Result untouched.
    @(negedge CLK);
    Start = 1'b1; Funct3 = 3'b000; OpA = 32'd5; OpB = 32'd6;
    @(negedge CLK);
    Start = 1'b0;
    ndone = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (Done) ndone++;
      if (cyc == 10) check("flush.busy_before", {31'd0, Busy}, 32'd1);
      if (cyc == 11) check("flush.busy_after", {31'd0, Busy}, 32'd0);
      Flush = (cyc == 10);
      @(negedge CLK);
    end
    check("flush.done_count", 32'(ndone), 32'd0);
    check("flush.result_kept", Result, 32'h0012_3450);

    // Asynchronous reset in the middle of CALC.
    @(negedge CLK);
    Start = 1'b1; Funct3 = 3'b011; OpA = 32'hFFFF_FFFF; OpB = 32'h2;
    @(negedge CLK);
    Start = 1'b0;
    repeat (14) @(negedge CLK);
    check("rst_mid.busy_before", {31'd0, Busy}, 32'd1);
    RST_N = 1'b0;
    #1;
    check("rst_mid.busy", {31'd0, Busy}, 32'd0);
    check("rst_mid.done", {31'd0, Done}, 32'd0);
    check("rst_mid.result", Result, 32'd0);
    check("rst_mid.illegal", {31'd0, Illegal}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    run_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 34, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the latched `rs1val`/`rs2val` operands and funct3 and returns a 32-bit result after a fixed 34-cycle latency. While it works it asserts `Busy`, which the hazard logic uses to stall PC, IF/ID and ID/EX.

## Interface
- `XLEN`, default 32: operand and result width; only 32 is supported.
- `CLK`  in  1: clock; all state changes on the rising edge.
- `RST_N`  in  1: asynchronous, active-low reset.
- `Start`  in  1: request; sampled only in IDLE.
- `Funct3`  in  3: RV32M op. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `OpA`  in  XLEN: rs1 value (dividend or multiplicand).
- `OpB`  in  XLEN: rs2 value (divisor or multiplier).
- `Flush`  in  1: synchronous abort of the current operation.
- `Busy`  out  1: asserted whenever the state is not IDLE.
- `Done`  out  1: one-cycle pulse; `Result` is valid.
- `Result`  out  XLEN: output value, held until the next accepted Start.
- `Illegal`  out  1: divide op requested while divide support is compiled out.

## Operation
- Reset values: state IDLE, `Busy`=0, `Done`=0, `Result`=0, `Illegal`=0, all internal registers 0.
- States and transitions:
  - IDLE → CALC when `Start` is sampled high.
  - CALC → SIGN after 32 iterations.
  - SIGN → DONE.
  - DONE → IDLE.
- On Start, the block latches `Funct3`, the operand magnitudes and the result sign.
  - Signed operands: DIV, REM, MULH, and OpA of MULHSU.
  - Result sign for products: XOR of the operand signs.
  - Result sign for quotients: XOR of the operand signs.
  - Result sign for remainders: the sign of the dividend.
- CALC uses a 6-bit iteration counter running 0..31.
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring divide, one quotient bit per cycle, 33-bit partial remainder.
- SIGN stage:
  - Negates the magnitude result if the sign flag is set.
  - Selects the low word (MUL), the high word (MULH/MULHSU/MULHU), the quotient or the remainder.
  - Writes `Result`.
- Divide-by-zero (OpB=0), resolved in SIGN:
  - Quotient = 0xFFFFFFFF for DIV and DIVU.
  - Remainder = OpA unchanged.
- Signed overflow (DIV with 0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0.
- `Start` is ignored outside IDLE, including in DONE.
- `Flush` in any non-IDLE state:
  - Next state is IDLE.
  - `Done` is not pulsed.
  - `Result` keeps its previous value.
  - `Flush` takes priority over `Start` in the same cycle.
- Reset asserted mid-operation returns the block to its reset values immediately (asynchronously).

## Timing
- Start sampled at edge 0; CALC covers cycles 1–32; SIGN is cycle 33; DONE is cycle 34.
- `Busy` is high in cycles 1–34. `Done` is high in cycle 34 only.
- The latency is fixed at 34 cycles for all ops, including the special cases. There is no early-out.
- A new Start can be accepted in cycle 35, the first IDLE cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `RV32M_DIV_EN`.
- Defined:
  - Full divide datapath and REM support.
  - `Illegal` is tied to 0.
- Undefined:
  - Divide logic is removed.
  - Funct3[2]=1 goes IDLE → DONE in one cycle, so `Done` appears in cycle 1.
  - `Result`=0 and `Illegal`=1 for that DONE cycle; `Illegal` returns to 0 at the next edge.
  - Multiply ops are unchanged.

## Structure
- Package `muldiv_pkg` holds:
  - The funct3 localparams (`F3_MUL` … `F3_REMU`).
  - The state enum (IDLE, CALC, SIGN, DONE).
  - `ITERS`=32.
- Sub-module `muldiv_sign_fix`: combinational absolute-value and conditional-negate. It is instantiated twice, once at operand capture and once at the result.

## Test plan
- MUL 7 × 0xFFFFFFFD (-3) → `Result`=0xFFFFFFEB; `Done` only in cycle 34; `Busy` only in cycles 1–34.
- High-word products:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide: DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Divide special cases:
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Control boundaries:
  - `Flush` in cycle 10 → IDLE at cycle 11, no `Done`, `Result` unchanged.
  - `Start` pulsed in cycle 20 is ignored.
  - `RST_N` low mid-CALC → all outputs 0 immediately.
- With `RV32M_DIV_EN` undefined: DIV → `Done` and `Illegal` in cycle 1 with `Result`=0; MUL 3×4 → 12 in cycle 34.
